// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce bank.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_HELD = 2'd2
  } ch_state_t;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: synchroniser, debouncer, edge pulses, long-press and auto-repeat.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DB_COUNT     = 1_000_000,
  parameter int HOLD_COUNT   = 32_500_000,
  parameter int REPEAT_COUNT = 6_500_000
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic noisy_in,
  input  logic repeat_en,
  output logic clean_out,
  output logic rise_out,
  output logic fall_out,
  output logic hold_out,
  output logic repeat_out
);

  localparam int DB_W  = cnt_w(DB_COUNT);
  localparam int HLD_W = cnt_w(HOLD_COUNT);
  localparam int REP_W = cnt_w(REPEAT_COUNT);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_COUNT - 1);
  localparam logic [HLD_W-1:0] HLD_MAX = HLD_W'(HOLD_COUNT - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   cand;
  logic [DB_W-1:0]        db_cnt;
  logic [HLD_W-1:0]       hold_cnt;
  logic [REP_W-1:0]       rep_cnt;
  ch_state_t              state;
  logic                   settle, rise_c, fall_c;

  assign s = sync_q[SYNC_STAGES-1];

  // Candidate has been stable long enough and differs from the current clean level.
  assign settle = (db_cnt == DB_MAX) && (cand == s) && (cand != clean_out);
  assign rise_c = settle & cand;
  assign fall_c = settle & ~cand;

  // Metastability synchroniser on the raw pin.
  always_ff @(posedge clock_in) begin
    if (reset_in) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
  end

  // Stability counter and clean level with registered edge pulses.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      cand      <= 1'b0;
      db_cnt    <= '0;
      clean_out <= 1'b0;
      rise_out  <= 1'b0;
      fall_out  <= 1'b0;
    end else begin
      if (s != cand) begin
        cand   <= s;
        db_cnt <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (settle) clean_out <= cand;
      rise_out <= rise_c;
      fall_out <= fall_c;
    end
  end

  // Press-duration FSM; a release always wins over hold/repeat in the same cycle.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state      <= S_LOW;
      hold_cnt   <= '0;
      rep_cnt    <= '0;
      hold_out   <= 1'b0;
      repeat_out <= 1'b0;
    end else begin
      hold_out   <= 1'b0;
      repeat_out <= 1'b0;
      case (state)
        S_LOW: begin
          if (rise_c) begin
            state    <= S_HIGH;
            hold_cnt <= '0;
          end
        end
        S_HIGH: begin
          if (fall_c) begin
            state <= S_LOW;
          end else if (hold_cnt == HLD_MAX) begin
            hold_out <= 1'b1;
            rep_cnt  <= '0;
            state    <= S_HELD;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (fall_c) begin
            state <= S_LOW;
          end else if (rep_cnt == REP_MAX) begin
            // Cadence keeps running when repeat is disabled; only the pulse is masked.
            rep_cnt    <= '0;
            repeat_out <= repeat_en;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        default: state <= S_LOW;
      endcase
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels; pure wiring around debounce_chan.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH         = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DB_COUNT     = 1_000_000,
  parameter int HOLD_COUNT   = 32_500_000,
  parameter int REPEAT_COUNT = 6_500_000
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic [N_CH-1:0] noisy_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] hold_out,
  output logic [N_CH-1:0] repeat_out
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_COUNT    (DB_COUNT),
      .HOLD_COUNT  (HOLD_COUNT),
      .REPEAT_COUNT(REPEAT_COUNT)
    ) u_chan (
      .clock_in  (clock_in),
      .reset_in  (reset_in),
      .noisy_in  (noisy_in[i]),
      .repeat_en (repeat_en[i]),
      .clean_out (clean_out[i]),
      .rise_out  (rise_out[i]),
      .fall_out  (fall_out[i]),
      .hold_out  (hold_out[i]),
      .repeat_out(repeat_out[i])
    );
  end

endmodule
